speed_divider: RTL

Sequential unsigned restoring divider that serves the encoder speed-measurement stage. It accepts a numerator (scaled time constant) and denominator (pulse-period count) on a one-cycle start strobe and computes one quotient bit per clock. It returns the quotient (speed magnitude) with a one-cycle ready pulse. It sits directly beside the speed calculator, driving its div_result/div_ready inputs from its div_start/num/denum outputs.

---
 rtl/speed_divider.sv | 108 ++++++++++
 1 files changed

// File: rtl/speed_divider.sv
// Unsigned restoring divider for speed measurement: num / denum -> quotient + remainder, one quotient bit per clock.
// Latency: 26 cycles from the sampled div_start to the registered div_ready pulse; one operation in flight.
// No backpressure: div_start while busy is dropped, and results are held until the next completion.
module speed_divider #(
   parameter int NUM_W = 25,
   parameter int DEN_W = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             div_start,
   input  logic [NUM_W-1:0] num,
   input  logic [DEN_W-1:0] denum,
   output logic [NUM_W-1:0] div_result,
   output logic [DEN_W-1:0] div_rem,
   output logic             div_ready,
   output logic             div_zero,
   output logic             busy
);

   localparam int CNT_W = (NUM_W > 1) ? $clog2(NUM_W) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [NUM_W-1:0] dividend;   // shifts out MSB-first into the remainder
   logic [NUM_W-1:0] quotient;   // shifts in one bit per CALC cycle
   logic [DEN_W-1:0] divisor;
   // After every step the remainder is below the divisor, so DEN_W bits hold it;
   // the extra bit needed for the compare lives only in the trial value.
   logic [DEN_W-1:0] rem;
   logic [CNT_W-1:0] bit_cnt;
   logic             zero_next;

   logic [DEN_W:0]   trial;
   logic             take;

   // Trial subtraction for the current quotient bit, compared at DEN_W+1 bits so it cannot overflow.
   always_comb begin
      trial = {rem, dividend[NUM_W-1]};
      take  = (trial >= {1'b0, divisor});
   end

   // Control FSM and datapath; all outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         dividend   <= '0;
         quotient   <= '0;
         divisor    <= '0;
         rem        <= '0;
         bit_cnt    <= '0;
         zero_next  <= 1'b0;
         div_result <= '0;
         div_rem    <= '0;
         div_ready  <= 1'b0;
         div_zero   <= 1'b0;
         busy       <= 1'b0;
      end else begin
         div_ready <= 1'b0;
         case (state)
            IDLE: begin
               if (div_start) begin
                  dividend  <= num;
                  divisor   <= denum;
                  rem       <= '0;
                  quotient  <= '0;
                  bit_cnt   <= CNT_W'(NUM_W - 1);
                  zero_next <= (denum == '0);
                  busy      <= 1'b1;
                  state     <= CALC;
               end
            end
            CALC: begin
               // A zero divisor always "takes", giving all-ones quotient and num's low bits as remainder.
               if (take) begin
                  rem <= DEN_W'(trial - {1'b0, divisor});
               end else begin
                  rem <= trial[DEN_W-1:0];
               end
               quotient <= {quotient[NUM_W-2:0], take};
               dividend <= {dividend[NUM_W-2:0], 1'b0};
               if (bit_cnt == '0) begin
                  state <= DONE;
               end else begin
                  bit_cnt <= bit_cnt - 1'b1;
               end
            end
            DONE: begin
               div_result <= quotient;
               div_rem    <= rem;
               div_zero   <= zero_next;
               div_ready  <= 1'b1;
               busy       <= 1'b0;
               state      <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
